cmd_frame_rx: RTL

//  Parametrised successor to the 4-byte command collector. Assembles FRAME_BYTES bytes,

---
 rtl/cmd_pkg.sv | 26 ++
 rtl/crc8_byte.sv | 15 +
 rtl/cmd_frame_rx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// Shared types and helpers for the command frame receiver.
// Holds the CRC-8 step function and the FSM state encoding.
package cmd_pkg;

    localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

    // One byte of MSB-first CRC-8, no reflection, no final XOR.
    function automatic logic [7:0] crc8_step(
        input logic [7:0] crc,
        input logic [7:0] data,
        input logic [7:0] poly
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_byte.sv
// Combinational single-byte CRC-8 step.
// Wraps the package function so the top carries exactly one CRC datapath.
module crc8_byte
    import cmd_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY_DEFAULT
) (
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    assign crc_out = crc8_step(crc_in, data_in, POLY);

endmodule

// File: rtl/cmd_frame_rx.sv
// Command frame receiver: collects toggle-strobed bytes into a frame,
// checks a trailing CRC-8 and holds the result on a valid/ready register.
module cmd_frame_rx
    import cmd_pkg::*;
#(
    parameter int         FRAME_BYTES    = 4,
    parameter bit         CRC_EN         = 1'b1,
    parameter logic [7:0] CRC_POLY       = CRC8_POLY_DEFAULT,
    parameter logic [7:0] CRC_INIT       = 8'h00,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [7:0]               in_byte,
    input  logic                     byte_tog,
    output logic [FRAME_BYTES*8-1:0] frame_data,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic                     crc_ok,
    output logic                     busy,
    output logic                     overrun,
    output logic                     timeout
);

    localparam int FW = FRAME_BYTES * 8;
    localparam int PW = FW - 8;
    localparam int IW = $clog2(FRAME_BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      crc_q, crc_d;
    logic [PW-1:0]   shift_q, shift_d;
    logic [15:0]     tcnt_q, tcnt_d;
    logic            tog_q, tog_d;
    logic            armed_q, armed_d;
    logic [FW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic            crc_ok_q, crc_ok_d;
    logic            overrun_q, overrun_d;
    logic            timeout_q, timeout_d;

    logic            byte_stb;
    logic            complete;
    logic [7:0]      crc_seed;
    logic [7:0]      crc_next;
    logic [PW+7:0]   shift_in;

    assign byte_stb = en & armed_q & (byte_tog ^ tog_q);
    assign crc_seed = (state_q == ST_IDLE) ? CRC_INIT : crc_q;
    assign shift_in = {shift_q, in_byte};

    crc8_byte #(
        .POLY    (CRC_POLY)
    ) u_crc (
        .crc_in  (crc_seed),
        .data_in (in_byte),
        .crc_out (crc_next)
    );

    // Next-state logic: byte collection, timeout and the output holder.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        crc_d     = crc_q;
        shift_d   = shift_q;
        tcnt_d    = tcnt_q;
        tog_d     = byte_tog;
        armed_d   = 1'b1;
        data_d    = data_q;
        valid_d   = valid_q;
        crc_ok_d  = crc_ok_q;
        overrun_d = 1'b0;
        timeout_d = 1'b0;
        complete  = 1'b0;

        if (valid_q && frame_ready) begin
            valid_d = 1'b0;
        end

        if (en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (byte_stb) begin
                        shift_d = shift_in[PW-1:0];
                        crc_d   = crc_next;
                        idx_d   = IW'(1);
                        tcnt_d  = '0;
                        state_d = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (byte_stb) begin
                        tcnt_d = '0;
                        if (idx_q == LAST_IDX) begin
                            complete = 1'b1;
                            idx_d    = '0;
                            state_d  = ST_IDLE;
                        end else begin
                            shift_d = shift_in[PW-1:0];
                            crc_d   = crc_next;
                            idx_d   = idx_q + IW'(1);
                        end
                    end else if (TO_EN && tcnt_q == TO_LAST) begin
                        tcnt_d    = '0;
                        idx_d     = '0;
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (complete) begin
            if (!valid_q || frame_ready) begin
                data_d   = shift_in;
                valid_d  = 1'b1;
                crc_ok_d = CRC_EN ? (crc_q == in_byte) : 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // All state registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            crc_q     <= '0;
            shift_q   <= '0;
            tcnt_q    <= '0;
            tog_q     <= 1'b0;
            armed_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            crc_ok_q  <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            crc_q     <= crc_d;
            shift_q   <= shift_d;
            tcnt_q    <= tcnt_d;
            tog_q     <= tog_d;
            armed_q   <= armed_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            crc_ok_q  <= crc_ok_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign frame_data  = data_q;
    assign frame_valid = valid_q;
    assign crc_ok      = crc_ok_q;
    assign busy        = (state_q == ST_COLLECT);
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;

endmodule
